team_03_wbm_bridge: RTL and testbench

//  Upstream feeder for team_03's Wishbone master port (ADR_O/DAT_O/SEL_O/WE_O/STB_O/CYC_O, DAT_I/ACK_I).

---
 rtl/team_03_wbm_pkg.sv | 18 +
 rtl/team_03_wbm_req_fifo.sv | 54 +++++
 rtl/team_03_wbm_bridge.sv | 157 +++++++++++++++
 tb/tb_team_03_wbm_bridge.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/team_03_wbm_pkg.sv
// Shared types and constants for the team_03 Wishbone master bridge.
package team_03_wbm_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUS  = 1'b1
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    localparam logic [31:0] ERR_DATA = 32'hBADC_0DE0;

endpackage

// File: rtl/team_03_wbm_req_fifo.sv
// Synchronous request FIFO; pointers wrap modulo DEPTH, count is one bit wider.
module team_03_wbm_req_fifo
    import team_03_wbm_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  req_t din,
    output req_t dout,
    output logic full,
    output logic empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/team_03_wbm_bridge.sv
// Request FIFO -> classic Wishbone master cycles -> in-order response register.
// Optional bus timeout enabled by defining TEAM03_WBM_TIMEOUT_EN.
module team_03_wbm_bridge
    import team_03_wbm_pkg::*;
#(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_adr,
    input  logic [31:0] req_dat,
    input  logic [3:0]  req_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] ADR_O,
    output logic [31:0] DAT_O,
    output logic [3:0]  SEL_O,
    output logic        WE_O,
    output logic        STB_O,
    output logic        CYC_O,
    input  logic [31:0] DAT_I,
    input  logic        ACK_I,
    output state_t      dbg_state
);

    // Handshakes: a beat transfers on a rising clk edge where valid && ready are both
    // high; the sender holds its payload stable from raising valid until that edge.

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("team_03_wbm_bridge: FIFO_DEPTH must be a power of two >= 2, TIMEOUT_CYCLES >= 1");
    end

    state_t state;
    state_t next_state;
    req_t   in_req;
    req_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   pop_head;
    logic   ack_hit;
    logic   bus_done;
    logic   timeout_hit;
    logic   cyc_q;

    assign in_req    = '{we: req_we, adr: req_adr, dat: req_dat, sel: req_sel};
    assign req_ready = !fifo_full;
    assign busy      = !fifo_empty || (state == BUS) || rsp_valid;
    assign CYC_O     = cyc_q;
    assign STB_O     = cyc_q;
    assign dbg_state = state;

    team_03_wbm_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (req_valid),
        .pop   (pop_head),
        .din   (in_req),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef TEAM03_WBM_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    // Counter equals the number of un-acked BUS cycles already elapsed.
    assign timeout_hit = (state == BUS) && !ACK_I && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign rsp_err     = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            if (pop_head)                     tmo_cnt <= '0;
            else if (state == BUS && !ACK_I)  tmo_cnt <= tmo_cnt + 1'b1;
            if (ack_hit)          err_q <= 1'b0;
            else if (timeout_hit) err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign rsp_err     = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!fifo_empty && !rsp_valid) next_state = BUS;
            BUS:     if (ACK_I || timeout_hit) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A pending response blocks the next pop so responses stay in bus order.
    always_comb begin
        pop_head = 1'b0;
        ack_hit  = 1'b0;
        bus_done = 1'b0;
        case (state)
            IDLE: pop_head = !fifo_empty && !rsp_valid;
            BUS: begin
                ack_hit  = ACK_I;
                bus_done = ACK_I || timeout_hit;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ADR_O <= '0;
            DAT_O <= '0;
            SEL_O <= '0;
            WE_O  <= 1'b0;
            cyc_q <= 1'b0;
        end else if (pop_head) begin
            ADR_O <= {head.adr[31:2], 2'b00};
            DAT_O <= head.we ? head.dat : 32'h0;
            SEL_O <= head.sel;
            WE_O  <= head.we;
            cyc_q <= 1'b1;
        end else if (bus_done) begin
            cyc_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= '0;
        end else if (ack_hit) begin
            rsp_valid <= 1'b1;
            rsp_dat   <= WE_O ? 32'h0 : DAT_I;
        end else if (timeout_hit) begin
            rsp_valid <= 1'b1;
            rsp_dat   <= ERR_DATA;
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_team_03_wbm_bridge.sv
// Self-checking bench for team_03_wbm_bridge: directed scenarios plus randomized traffic
// against a queue-based model of the expected Wishbone cycles and responses.
module tb_team_03_wbm_bridge;
    import team_03_wbm_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_adr = '0;
    logic [31:0] req_dat = '0;
    logic [3:0]  req_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic        busy;
    logic [31:0] ADR_O;
    logic [31:0] DAT_O;
    logic [3:0]  SEL_O;
    logic        WE_O;
    logic        STB_O;
    logic        CYC_O;
    logic [31:0] DAT_I = '0;
    logic        ACK_I = 1'b0;
    state_t      dbg_state;

    int   total = 0;
    int   bad = 0;
    req_t exp_q[$];

    team_03_wbm_bridge dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adr(req_adr), .req_dat(req_dat), .req_sel(req_sel),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
        .rsp_err(rsp_err), .busy(busy),
        .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O),
        .STB_O(STB_O), .CYC_O(CYC_O), .DAT_I(DAT_I), .ACK_I(ACK_I),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected bus view of a request: word-aligned address, write data only on writes.
    function automatic req_t model_bus(input logic we, input logic [31:0] adr,
                                       input logic [31:0] dat, input logic [3:0] sel);
        req_t r;
        r.we  = we;
        r.adr = adr & 32'hFFFF_FFFC;
        r.dat = we ? dat : 32'h0;
        r.sel = sel;
        return r;
    endfunction

    // driver tasks
    task automatic push_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                            input logic [3:0] sel, output bit ok);
        req_valid = 1'b1; req_we = we; req_adr = adr; req_dat = dat; req_sel = sel;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) begin
            exp_q.push_back(model_bus(we, adr, dat, sel));
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_cyc(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (CYC_O) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic do_ack(input logic [31:0] d);
        ACK_I = 1'b1; DAT_I = d;
        tick();
        ACK_I = 1'b0; DAT_I = $urandom;
    endtask

    task automatic take_rsp(output logic [31:0] d, output logic e, output bit ok);
        ok = 1'b0; d = '0; e = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rsp_valid) begin ok = 1'b1; break; end
            tick();
        end
        if (ok) begin
            d = rsp_dat; e = rsp_err;
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic push_random(output bit ok);
        push_req(1'($urandom), $urandom, $urandom, 4'($urandom_range(1, 15)), ok);
    endtask

    // Scoreboard: serves n queued cycles in order with random ACK delay and checks each response.
    task automatic drain_and_check(input int n);
        req_t        exp;
        logic [31:0] d, rd;
        logic        e;
        bit          ok;
        int          dly;
        for (int k = 0; k < n; k++) begin
            wait_cyc(ok);
            total++; if (!ok) begin bad++; $display("FAIL drain_cyc: CYC_O=%b want 1", CYC_O); end
            total++; if (exp_q.size() == 0) begin bad++; $display("FAIL drain_model_empty: size=0 want >0"); end
            else begin
                exp = exp_q.pop_front();
                total++; if ({WE_O, ADR_O, DAT_O, SEL_O} !== exp) begin bad++;
                    $display("FAIL drain_bus: got %b/%h/%h/%h want %b/%h/%h/%h", WE_O, ADR_O, DAT_O, SEL_O, exp.we, exp.adr, exp.dat, exp.sel); end
                dly = $urandom_range(0, 3);
                for (int j = 0; j < dly; j++) begin
                    tick();
                    total++; if (STB_O !== 1'b1 || ADR_O !== exp.adr) begin bad++;
                        $display("FAIL drain_hold: STB_O=%b ADR_O=%h want 1/%h", STB_O, ADR_O, exp.adr); end
                end
                d = $urandom;
                do_ack(d);
                total++; if (CYC_O !== 1'b0) begin bad++; $display("FAIL drain_cyc_drop: CYC_O=%b want 0", CYC_O); end
                take_rsp(rd, e, ok);
                total++; if (!ok || rd !== (exp.we ? 32'h0 : d) || e !== 1'b0) begin bad++;
                    $display("FAIL drain_rsp: ok=%b dat=%h err=%b want 1/%h/0", ok, rd, e, exp.we ? 32'h0 : d); end
            end
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) tick();
        total++; if ({req_ready, rsp_valid, busy, CYC_O, STB_O, WE_O} !== 6'b100000) begin bad++;
            $display("FAIL reset_ctl: rdy/rv/busy/cyc/stb/we=%b want 100000", {req_ready, rsp_valid, busy, CYC_O, STB_O, WE_O}); end
        total++; if ({ADR_O, DAT_O, SEL_O, rsp_dat, rsp_err} !== '0) begin bad++;
            $display("FAIL reset_data: adr=%h dat=%h sel=%h rdat=%h err=%b want 0", ADR_O, DAT_O, SEL_O, rsp_dat, rsp_err); end
        total++; if (dbg_state !== IDLE) begin bad++; $display("FAIL reset_state: got %0d want IDLE", dbg_state); end
        @(negedge clk); rst_i = 1'b0;
        tick();
        do_ack(32'hDEAD_BEEF);
        tick();
        total++; if (rsp_valid !== 1'b0 || CYC_O !== 1'b0 || busy !== 1'b0) begin bad++;
            $display("FAIL idle_ack_ignored: rsp_valid=%b CYC_O=%b busy=%b want 0", rsp_valid, CYC_O, busy); end
    endtask

    task automatic test_write();
        bit ok; logic [31:0] rd; logic e; req_t exp;
        push_req(1'b1, 32'h3000_0004, 32'hA5A5_5A5A, 4'hF, ok);
        total++; if (!ok || CYC_O !== 1'b0) begin bad++; $display("FAIL wr_latency0: ok=%b CYC_O=%b want 1/0", ok, CYC_O); end
        tick();
        exp = exp_q.pop_front();
        total++; if ({CYC_O, STB_O, WE_O} !== 3'b111 || {ADR_O, DAT_O, SEL_O} !== {exp.adr, exp.dat, exp.sel}) begin bad++;
            $display("FAIL wr_bus: cyc/stb/we=%b adr=%h dat=%h sel=%h want 111/%h/%h/%h", {CYC_O, STB_O, WE_O}, ADR_O, DAT_O, SEL_O, exp.adr, exp.dat, exp.sel); end
        repeat (2) begin
            tick();
            total++; if (STB_O !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL wr_wait: STB_O=%b rsp_valid=%b want 1/0", STB_O, rsp_valid); end
        end
        do_ack($urandom);
        total++; if (CYC_O !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== 32'h0 || rsp_err !== 1'b0) begin bad++;
            $display("FAIL wr_rsp: cyc=%b rv=%b dat=%h err=%b want 0/1/0/0", CYC_O, rsp_valid, rsp_dat, rsp_err); end
        take_rsp(rd, e, ok);
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL wr_done: rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_read();
        bit ok; logic [31:0] rd; logic e; int seen;
        push_req(1'b0, 32'h3000_0010, 32'hFFFF_0000, 4'hF, ok);
        wait_cyc(ok);
        void'(exp_q.pop_front());
        total++; if (!ok || WE_O !== 1'b0 || DAT_O !== 32'h0 || ADR_O !== 32'h3000_0010) begin bad++;
            $display("FAIL rd_bus: ok=%b we=%b dat=%h adr=%h want 1/0/0/30000010", ok, WE_O, DAT_O, ADR_O); end
        do_ack(32'h1234_5678);
        total++; if (CYC_O !== 1'b0 || rsp_dat !== 32'h1234_5678) begin bad++;
            $display("FAIL rd_rsp: CYC_O=%b rsp_dat=%h want 0/12345678", CYC_O, rsp_dat); end
        take_rsp(rd, e, ok);
        seen = 0;
        repeat (4) begin if (rsp_valid) seen++; tick(); end
        total++; if (seen !== 0 || rd !== 32'h1234_5678) begin bad++; $display("FAIL rd_once: extra=%0d dat=%h want 0/12345678", seen, rd); end
    endtask

    task automatic test_full();
        bit ok; logic [31:0] d0, rd; logic e; req_t exp;
        push_req(1'b0, 32'h4000_0000, 32'h0, 4'h3, ok);
        wait_cyc(ok);
        exp = exp_q.pop_front();
        d0 = $urandom;
        do_ack(d0);
        for (int k = 0; k < 4; k++) begin
            push_random(ok);
            total++; if (!ok) begin bad++; $display("FAIL full_push%0d: accepted=0 want 1", k); end
        end
        total++; if (req_ready !== 1'b0 || CYC_O !== 1'b0) begin bad++; $display("FAIL full_ready: req_ready=%b CYC_O=%b want 0/0", req_ready, CYC_O); end
        req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h5000_0007; req_dat = $urandom; req_sel = 4'h9;
        repeat (3) tick();
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_hold: req_ready=%b want 0", req_ready); end
        total++; if (rsp_dat !== d0) begin bad++; $display("FAIL full_pending_rsp: got %h want %h", rsp_dat, d0); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (req_ready !== 1'b0 || CYC_O !== 1'b0 || rsp_valid !== 1'b0) begin bad++;
            $display("FAIL full_after_take: rdy=%b cyc=%b rv=%b want 0/0/0", req_ready, CYC_O, rsp_valid); end
        tick();
        total++; if (req_ready !== 1'b1 || CYC_O !== 1'b1) begin bad++; $display("FAIL full_pop: rdy=%b cyc=%b want 1/1", req_ready, CYC_O); end
        exp_q.push_back(model_bus(req_we, req_adr, req_dat, req_sel));
        tick();
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL full_fifth: req_ready=%b want 0", req_ready); end
        drain_and_check(5);
    endtask

    task automatic test_rsp_stall();
        bit ok; logic [31:0] d0, rd; logic e; int starts;
        push_random(ok);
        push_random(ok);
        wait_cyc(ok);
        void'(exp_q.pop_front());
        d0 = $urandom;
        do_ack(d0);
        starts = 0;
        repeat (6) begin tick(); if (CYC_O) starts++; end
        total++; if (starts !== 0 || rsp_valid !== 1'b1) begin bad++; $display("FAIL stall_block: cyc_cycles=%0d rv=%b want 0/1", starts, rsp_valid); end
        rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
        total++; if (CYC_O !== 1'b0) begin bad++; $display("FAIL stall_release0: CYC_O=%b want 0", CYC_O); end
        tick();
        total++; if (CYC_O !== 1'b1) begin bad++; $display("FAIL stall_release1: CYC_O=%b want 1", CYC_O); end
        drain_and_check(1);
    endtask

    task automatic test_timeout();
        bit ok; logic [31:0] rd; logic e; int n;
        push_req(1'b0, 32'h6000_0020, 32'h0, 4'hF, ok);
        wait_cyc(ok);
        void'(exp_q.pop_front());
`ifdef TEAM03_WBM_TIMEOUT_EN
        n = 0;
        while (CYC_O && n < 400) begin n++; tick(); end
        total++; if (n !== 255) begin bad++; $display("FAIL tmo_len: stb_cycles=%0d want 255", n); end
        take_rsp(rd, e, ok);
        total++; if (!ok || e !== 1'b1 || rd !== 32'hBADC_0DE0) begin bad++; $display("FAIL tmo_rsp: ok=%b err=%b dat=%h want 1/1/badc0de0", ok, e, rd); end
`else
        n = 0;
        repeat (300) begin if (CYC_O) n++; tick(); end
        total++; if (n !== 300 || rsp_valid !== 1'b0) begin bad++; $display("FAIL no_tmo_wait: cyc_cycles=%0d rv=%b want 300/0", n, rsp_valid); end
        do_ack(32'h0BAD_F00D);
        take_rsp(rd, e, ok);
        total++; if (!ok || e !== 1'b0 || rd !== 32'h0BAD_F00D) begin bad++; $display("FAIL no_tmo_rsp: ok=%b err=%b dat=%h want 1/0/0badf00d", ok, e, rd); end
`endif
    endtask

    task automatic test_random();
        bit ok; int n;
        for (int b = 0; b < 8; b++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                push_random(ok);
                total++; if (!ok) begin bad++; $display("FAIL rand_push: accepted=0 want 1"); end
            end
            drain_and_check(n);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        push_random(ok); push_random(ok); push_random(ok);
        wait_cyc(ok);
        total++; if (STB_O !== 1'b1) begin bad++; $display("FAIL rstmid_pre: STB_O=%b want 1", STB_O); end
        #2 rst_i = 1'b1;
        #1;
        exp_q.delete();
        total++; if ({CYC_O, STB_O, busy, rsp_valid} !== 4'b0000) begin bad++;
            $display("FAIL rstmid_async: cyc/stb/busy/rv=%b want 0000", {CYC_O, STB_O, busy, rsp_valid}); end
        @(negedge clk); rst_i = 1'b0;
        repeat (3) tick();
        total++; if ({req_ready, CYC_O, busy} !== 3'b100) begin bad++; $display("FAIL rstmid_after: rdy/cyc/busy=%b want 100", {req_ready, CYC_O, busy}); end
        push_random(ok);
        drain_and_check(1);
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_full();
        test_rsp_stall();
        test_timeout();
        test_random();
        test_reset_mid();
        total++; if (exp_q.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL end_idle: left=%0d busy=%b want 0/0", exp_q.size(), busy); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
